// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter: parity modes,
// FSM state encoding and an elaboration-time clog2 helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK,
        ST_MARK
    } state_t;

    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready character stream into the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_cfg_fifo.sv
// Synchronous transmit FIFO; a write while full and a read while empty are ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Run-time configurable UART transmitter (divisor, parity, stop bits) fed by a FIFO.
// Optional line-break generation is built only when UART_TX_BREAK_EN is defined.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_cfg_if.slave                in_if,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                        break_req,
`endif
    output logic                        tx_out,
    output logic                        busy,
    output logic                        tx_done,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int CNT_W = DIV_W + 1;
    localparam int IDX_W = clog2(DATA_BITS);

    state_t               state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 tx_done_q, tx_done_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic [DIV_W-1:0]     div_eff;
    logic [CNT_W-1:0]     bit_reload, stop_reload;
    logic                 cnt_zero, start_frame;

    assign in_if.in_ready = !fifo_full;
    assign fifo_push      = in_if.in_valid && !fifo_full;
    assign div_eff        = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    assign bit_reload     = {1'b0, div_q} - CNT_W'(1);
    assign stop_reload    = stop2_q ? ({div_q, 1'b0} - CNT_W'(1)) : bit_reload;
    assign cnt_zero       = (cnt_q == '0);

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_if.in_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        tx_done_d   = 1'b0;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;
        busy_d      = (state_q != ST_IDLE) || !fifo_empty;

        case (state_q)
            ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_d = ST_BREAK;
                    tx_d    = 1'b0;
                end else if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
`else
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
`endif
            end
            ST_START: begin
                if (cnt_zero) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    cnt_d   = bit_reload;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                    if (par_en_q) begin
                        state_d = ST_PARITY;
                        tx_d    = par_bit_q;
                        cnt_d   = bit_reload;
                    end else begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                        cnt_d   = stop_reload;
                    end
                end else begin
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = bit_reload;
                end
            end
            ST_PARITY: begin
                if (cnt_zero) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    cnt_d   = stop_reload;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_zero) begin
                    tx_done_d = 1'b1;
                    state_d   = ST_IDLE;
                    if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_TX_BREAK_EN
            // Releasing a break always guarantees one full bit of mark time.
            ST_BREAK: begin
                if (!break_req) begin
                    state_d = ST_MARK;
                    tx_d    = 1'b1;
                    cnt_d   = {1'b0, div_eff} - CNT_W'(1);
                end
            end
            ST_MARK: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame configuration is captured only here, so mid-frame cfg changes wait.
        if (start_frame) begin
            fifo_pop  = 1'b1;
            state_d   = ST_START;
            tx_d      = 1'b0;
            div_d     = div_eff;
            cnt_d     = {1'b0, div_eff} - CNT_W'(1);
            shift_d   = fifo_rd_data;
            stop2_d   = cfg_stop2;
            par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            par_bit_d = (^fifo_rd_data) ^ (cfg_parity == PAR_ODD);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            shift_q   <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
        end
    end

    assign tx_out  = tx_q;
    assign tx_done = tx_done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: table of single frames plus FIFO, reset-abort
// and mid-frame reconfiguration sequences.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 24;

    logic             clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_parity;
    logic             cfg_stop2;
`ifdef UART_TX_BREAK_EN
    logic             break_req;
`endif
    logic             tx_out;
    logic             busy;
    logic             tx_done;
    logic [2:0]       fifo_level;

    int checks   = 0;
    int failures = 0;

    uart_tx_cfg_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_tx_cfg #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (bus),
        .cfg_div    (cfg_div),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
`ifdef UART_TX_BREAK_EN
        .break_req  (break_req),
`endif
        .tx_out     (tx_out),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // exp holds one entry per bit-time slot, slot 0 (start bit) leftmost.
    typedef struct {
        logic [7:0]       data;
        logic [DIV_W-1:0] div;
        logic [1:0]       parity;
        logic             stop2;
        int               div_eff;
        int               slots;
        logic [0:15]      exp;
        string            name;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [7:0] data);
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic bit8N1(input logic [7:0] d, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        return 1'b1;
    endfunction

    task automatic runVector(input vec_t v);
        int errs;
        int dones;
        errs  = 0;
        dones = 0;
        cfg_div    = v.div;
        cfg_parity = v.parity;
        cfg_stop2  = v.stop2;
        applyStimulus(v.data);
        checkOutput({v.name, "_level"}, 32'(fifo_level), 32'd1);
        @(negedge clk);
        for (int i = 0; i < v.div_eff * v.slots; i++) begin
            if (tx_out !== v.exp[i / v.div_eff]) errs++;
            if (tx_done) dones++;
            @(negedge clk);
        end
        checkOutput({v.name, "_serial_errs"}, 32'(errs), 32'd0);
        checkOutput({v.name, "_early_done"}, 32'(dones), 32'd0);
        checkOutput({v.name, "_done"}, 32'(tx_done), 32'd1);
        checkOutput({v.name, "_busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({v.name, "_done_end"}, 32'(tx_done), 32'd0);
        checkOutput({v.name, "_busy_end"}, 32'(busy), 32'd0);
        checkOutput({v.name, "_idle_line"}, 32'(tx_out), 32'd1);
    endtask

    initial begin
        logic [7:0] d [6];
        int accepted;
        int errs;
        int dones;
        int lows;
        logic exp_bit;

        vecs[0] = '{8'hA5, 24'd4, 2'd0, 1'b0, 4, 10, 16'b0101001011000000, "8N1_A5"};
        vecs[1] = '{8'h07, 24'd4, 2'd1, 1'b0, 4, 11, 16'b0111000001100000, "even_07"};
        vecs[2] = '{8'h07, 24'd4, 2'd2, 1'b0, 4, 11, 16'b0111000000100000, "odd_07"};
        vecs[3] = '{8'hFF, 24'd3, 2'd0, 1'b1, 3, 11, 16'b0111111111100000, "stop2_FF"};
        vecs[4] = '{8'h3C, 24'd1, 2'd1, 1'b1, 2, 12, 16'b0001111000110000, "div1_even_3C"};
        vecs[5] = '{8'h80, 24'd0, 2'd3, 1'b0, 2, 10, 16'b0000000011000000, "div0_par3_80"};

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        cfg_div      = 24'd4;
        cfg_parity   = 2'd0;
        cfg_stop2    = 1'b0;
`ifdef UART_TX_BREAK_EN
        break_req    = 1'b0;
`endif

        #12;
        checkOutput("rst_tx_out", 32'(tx_out), 32'd1);
        checkOutput("rst_tx_done", 32'(tx_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("post_rst_tx", 32'(tx_out), 32'd1);

        for (int k = 0; k < 6; k++) begin
            runVector(vecs[k]);
        end

        // Six back-to-back writes at div=2 8N1: five accepted, frames gap-free.
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        cfg_div    = 24'd2;
        cfg_parity = 2'd0;
        cfg_stop2  = 1'b0;
        accepted   = 0;
        for (int k = 0; k < 6; k++) begin
            bus.in_data  = d[k];
            bus.in_valid = 1'b1;
            if (bus.in_ready) accepted++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checkOutput("fifo_accepted", 32'(accepted), 32'd5);
        checkOutput("fifo_full_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("fifo_full_level", 32'(fifo_level), 32'd4);
        errs  = 0;
        dones = 0;
        for (int i = 4; i < 100; i++) begin
            exp_bit = bit8N1(d[i / 20], (i % 20) / 2);
            if (tx_out !== exp_bit) errs++;
            if (tx_done) dones++;
            @(negedge clk);
        end
        checkOutput("fifo_stream_errs", 32'(errs), 32'd0);
        checkOutput("fifo_done_count", 32'(dones), 32'd4);
        checkOutput("fifo_last_done", 32'(tx_done), 32'd1);
        @(negedge clk);
        checkOutput("fifo_drained_busy", 32'(busy), 32'd0);
        checkOutput("fifo_drained_level", 32'(fifo_level), 32'd0);

        // Reset during data bit 3 with a second character still queued.
        cfg_div = 24'd4;
        applyStimulus(8'hA5);
        applyStimulus(8'h5A);
        for (int i = 0; i < 17; i++) @(negedge clk);
        checkOutput("abort_bit3_low", 32'(tx_out), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("abort_tx_high", 32'(tx_out), 32'd1);
        checkOutput("abort_level", 32'(fifo_level), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (tx_done) dones++;
        end
        reset = 1'b1;
        lows  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_out !== 1'b1) lows++;
            if (tx_done) dones++;
        end
        checkOutput("abort_no_done", 32'(dones), 32'd0);
        checkOutput("abort_discarded", 32'(lows), 32'd0);
        runVector(vecs[0]);

        // Divisor raised mid-frame: only the following frame slows down.
        cfg_div    = 24'd4;
        cfg_parity = 2'd0;
        cfg_stop2  = 1'b0;
        applyStimulus(8'hA5);
        @(negedge clk);
        errs  = 0;
        dones = 0;
        for (int i = 0; i < 120; i++) begin
            if (i == 2) begin
                bus.in_data  = 8'h0F;
                bus.in_valid = 1'b1;
            end
            if (i == 3) bus.in_valid = 1'b0;
            if (i == 10) cfg_div = 24'd8;
            exp_bit = (i < 40) ? bit8N1(8'hA5, i / 4) : bit8N1(8'h0F, (i - 40) / 8);
            if (tx_out !== exp_bit) errs++;
            if (tx_done) dones++;
            @(negedge clk);
        end
        checkOutput("cfgchg_serial_errs", 32'(errs), 32'd0);
        checkOutput("cfgchg_mid_done", 32'(dones), 32'd1);
        checkOutput("cfgchg_final_done", 32'(tx_done), 32'd1);
        @(negedge clk);
        checkOutput("cfgchg_busy_end", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
